// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register-index constants
// and a saturating counter helper.
package pipeline_pkg;

    localparam logic [1:0] HZ_RUN      = 2'd0;
    localparam logic [1:0] HZ_MEM_WAIT = 2'd1;
    localparam logic [1:0] HZ_ERROR    = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = HZ_RUN,
        ST_MEM_WAIT = HZ_MEM_WAIT,
        ST_ERROR    = HZ_ERROR
    } hz_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EX and the sources of the
// instruction in ID; $zero never creates a dependency.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait FSM with watchdog,
// and a priority mux over freeze / taken branch / load-use / jump.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_jump,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_flush,
    output logic       ex_mem_write,
    output logic       mem_wb_bubble,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
`endif
    output logic       mem_timeout
);

    hz_state_t        state;
    logic [CNT_W-1:0] wait_cnt;
    logic             load_use;
    logic             mem_done;
    logic             freeze;

    load_use_detect u_lu (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use)
    );

    // A dropped request ends the wait just like a ready strobe.
    assign mem_done = mem_ready || !mem_req;
    assign freeze   = (state != ST_RUN) || (mem_req && !mem_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_done) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= ST_ERROR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Branch beats load-use: the ID instruction is on the wrong path and gets flushed.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!reset) begin
            if (freeze) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end else if (id_jump) begin
                if_id_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (!pc_write)
                perf_stall_cycles <= sat_inc32(perf_stall_cycles);
            if (if_id_flush || id_ex_flush)
                perf_flush_count <= sat_inc32(perf_flush_count);
        end
    end
`endif

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the flush input of the ID/EX register, the write enables of PC, IF/ID, ID/EX and EX/MEM, and the flush of IF/ID.
- Detects load-use hazards, taken branches (resolved in EX) and jumps (resolved in ID).
- Freezes the pipeline while a multi-cycle data-memory access is pending, with a watchdog timeout.

Parameters:
TIMEOUT_CYCLES, 64, max consecutive MEM_WAIT cycles before entering ERROR (>=2).
CNT_W, 7, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high; clears FSM and counter
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_jump  in  1  jump/jr/jal decoded in ID
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  5  rt (load destination) of instruction in EX
ex_branch_taken  in  1  branch in EX resolved taken
mem_req  in  1  MEM stage has an active load/store
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to nop
id_ex_write  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX bubble (RegWrite/MemWrite forced 0)
ex_mem_write  out  1  EX/MEM load enable
mem_wb_bubble  out  1  MEM/WB captures a bubble
mem_timeout  out  1  sticky error flag, registered

Behaviour:
- Clock is clk. Reset is reset: asynchronous, active-high, one clock domain.
- State register: RUN, MEM_WAIT, ERROR. Reset -> RUN, wait_cnt=0, mem_timeout=0.
- Outputs other than mem_timeout are combinational from state and inputs. Zero-latency: they act on the next rising edge.
- Values in RUN with no hazard (also the values while reset is held):
  - pc_write, if_id_write, id_ex_write, ex_mem_write = 1.
  - if_id_flush, id_ex_flush, mem_wb_bubble = 0.
- Load-use condition LU: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Priority, highest first:
  1. Freeze: state MEM_WAIT or ERROR, or (RUN && mem_req && !mem_ready). Effects: pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_bubble=1, both flushes 0.
  2. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1. LU ignored, because the ID instruction is wrong-path.
  3. LU: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble; the condition clears naturally once the load advances.
  4. id_jump: if_id_flush=1 only.
- Transitions:
  - RUN -> MEM_WAIT when mem_req && !mem_ready; wait_cnt<=1.
  - MEM_WAIT -> RUN when mem_ready. The freeze is still asserted in that cycle, so the MEM stage holds its result into the edge; the pipeline advances on the following edge.
  - MEM_WAIT with !mem_ready: wait_cnt++. When wait_cnt==TIMEOUT_CYCLES-1 and still !mem_ready -> ERROR, mem_timeout<=1.
  - ERROR: absorbing until reset; full freeze held.
- Deferred hazards: a branch or LU pending during a freeze is held stable by the frozen stages and is acted on in the first non-frozen cycle.
- mem_req deasserting while in MEM_WAIT is treated as mem_ready.
- Reset asserted mid-MEM_WAIT returns to RUN immediately and clears the counter.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0].
  - perf_stall_cycles increments every cycle pc_write==0.
  - perf_flush_count increments every cycle if_id_flush||id_ex_flush.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encoding constants HZ_RUN=2'd0, HZ_MEM_WAIT=2'd1, HZ_ERROR=2'd2;
  - register-index constant REG_ZERO=5'd0.
- One natural sub-module, load_use_detect: purely combinational LU compare, reusable by the forwarding unit.
- FSM, counter and priority mux stay in hazard_controller.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> exactly one cycle with pc_write=0, if_id_write=0, id_ex_flush=1. Repeat with ex_rt=0 -> no stall.
- Branch + LU in same cycle: ex_branch_taken=1 with LU true -> if_id_flush=1, id_ex_flush=1, pc_write=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> freeze outputs for 4 cycles, state RUN on 5th, mem_timeout=0.
- Timeout: TIMEOUT_CYCLES=4, mem_req=1, mem_ready never -> ERROR after 4 frozen cycles, mem_timeout=1 and sticky; later mem_ready=1 has no effect.
- Reset mid-wait: assert reset in MEM_WAIT cycle 2 -> RUN immediately, outputs at no-hazard values, counter 0.
- With HAZARD_PERF_CNT_EN: the LU scenario plus one taken branch -> perf_stall_cycles=1, perf_flush_count=2.
